// File: rtl/dca_matrix_mreg2store.sv
// Reads a resident matrix out of the mreg one row per cycle and streams it as tensor-row beats.
// Rows beyond the requested count are drained silently. Column masking: DCA_MATRIX_MREG2STORE_COL_MASK_EN.
module dca_matrix_mreg2store #(
    parameter int MATRIX_NUM_ROW   = 4,
    parameter int MATRIX_NUM_COL   = 4,
    parameter int BW_TENSOR_SCALAR = 32,
    parameter int BW_TENSOR_ROW    = MATRIX_NUM_COL * BW_TENSOR_SCALAR,
    parameter int BW_NUM_ROW       = $clog2(MATRIX_NUM_ROW + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     enable,
    output logic                     busy,
    output logic                     storereg_wready,
    input  logic                     storereg_wrequest,
    input  logic [BW_NUM_ROW-1:0]    store_num_row,
`ifdef DCA_MATRIX_MREG2STORE_COL_MASK_EN
    input  logic [$clog2(MATRIX_NUM_COL+1)-1:0] store_num_col,
`endif
    output logic                     mreg_move_renable,
    input  logic [BW_TENSOR_ROW-1:0] mreg_move_rdata_list1d,
    output logic                     store_tensor_row_rvalid,
    output logic                     store_tensor_row_rlast,
    output logic [BW_TENSOR_ROW-1:0] store_tensor_row_rdata,
    input  logic                     store_tensor_row_rready,
    output logic                     store_done
);

    localparam logic [BW_NUM_ROW-1:0] MAX_ROW  = BW_NUM_ROW'(MATRIX_NUM_ROW);
    localparam logic [BW_NUM_ROW-1:0] LAST_ROW = BW_NUM_ROW'(MATRIX_NUM_ROW - 1);

    typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_t;

    state_t                  state_q;
    logic [BW_NUM_ROW-1:0]   row_cnt_q;
    logic [BW_NUM_ROW-1:0]   num_q;
    logic [BW_NUM_ROW-1:0]   num_row_d;
    logic                    in_send;
    logic                    in_drain;
    logic                    hs;
    logic                    is_last;
    logic                    at_end;
    logic [BW_TENSOR_ROW-1:0] row_masked;

    assign num_row_d = (store_num_row > MAX_ROW) ? MAX_ROW : store_num_row;

    assign in_send  = (state_q == SEND);
    assign in_drain = (state_q == DRAIN);
    assign hs       = in_send & enable & store_tensor_row_rready;
    assign is_last  = in_send && (row_cnt_q == BW_NUM_ROW'(num_q - 1'b1));
    assign at_end   = (row_cnt_q == LAST_ROW);

    assign busy                    = (state_q != IDLE);
    assign storereg_wready         = (state_q == IDLE);
    assign store_tensor_row_rvalid = in_send & enable;
    assign store_tensor_row_rlast  = is_last;
    assign store_tensor_row_rdata  = in_send ? row_masked : '0;
    assign mreg_move_renable       = hs | (in_drain & enable);
    // The final mreg shift, whether it carried a beat or was a silent drain, completes the matrix.
    assign store_done              = (hs & is_last & at_end) | (in_drain & enable & at_end);

`ifdef DCA_MATRIX_MREG2STORE_COL_MASK_EN
    localparam int BW_NUM_COL = $clog2(MATRIX_NUM_COL + 1);
    localparam logic [BW_NUM_COL-1:0] MAX_COL = BW_NUM_COL'(MATRIX_NUM_COL);

    logic [BW_NUM_COL-1:0] num_col_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            num_col_q <= '0;
        end else if (enable && state_q == IDLE && storereg_wrequest) begin
            num_col_q <= (store_num_col > MAX_COL) ? MAX_COL : store_num_col;
        end
    end

    always_comb begin
        row_masked = mreg_move_rdata_list1d;
        for (int c = 0; c < MATRIX_NUM_COL; c++) begin
            if (c >= int'(num_col_q)) begin
                row_masked[c*BW_TENSOR_SCALAR +: BW_TENSOR_SCALAR] = '0;
            end
        end
    end
`else
    assign row_masked = mreg_move_rdata_list1d;
`endif

    // A zero row count still goes through DRAIN so the mreg always sees a full matrix of shifts.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q   <= IDLE;
            row_cnt_q <= '0;
            num_q     <= '0;
        end else if (enable) begin
            case (state_q)
                IDLE: begin
                    if (storereg_wrequest) begin
                        num_q     <= num_row_d;
                        row_cnt_q <= '0;
                        state_q   <= (num_row_d != '0) ? SEND : DRAIN;
                    end
                end
                SEND: begin
                    if (hs) begin
                        if (!is_last) begin
                            row_cnt_q <= row_cnt_q + 1'b1;
                        end else if (at_end) begin
                            row_cnt_q <= '0;
                            state_q   <= IDLE;
                        end else begin
                            row_cnt_q <= row_cnt_q + 1'b1;
                            state_q   <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (at_end) begin
                        row_cnt_q <= '0;
                        state_q   <= IDLE;
                    end else begin
                        row_cnt_q <= row_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dca_matrix_mreg2store.md
Name: dca_matrix_mreg2store

Overview:
- Store-side counterpart of the matrix-register load path.
- Once a matrix in the matrix register (mreg) is ready to store, the block reads it one row per cycle through the mreg move/shift port.
- Each row is emitted as a tensor-row stream beat with valid/ready handshaking, and the final emitted row is tagged last.
- When the destination tensor has fewer rows than the matrix, the surplus rows are drained from the mreg without being emitted. The mreg therefore always receives exactly MATRIX_NUM_ROW shifts per matrix.

Parameters:
- MATRIX_NUM_ROW, 4, rows per matrix; must be >= 1.
- MATRIX_NUM_COL, 4, scalars per row.
- BW_TENSOR_SCALAR, 32, bits per scalar.
- BW_TENSOR_ROW, MATRIX_NUM_COL*BW_TENSOR_SCALAR, row width (derived, do not override).
- BW_NUM_ROW, clog2(MATRIX_NUM_ROW+1), width of the row-count field (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- clear  in  1  synchronous abort; returns the block to IDLE.
- enable  in  1  when low, state and counter freeze and no handshake or shift occurs.
- busy  out  1  high in any state other than IDLE.
- storereg_wready  out  1  block is ready to accept a new matrix.
- storereg_wrequest  in  1  a matrix is resident in the mreg; start storing.
- store_num_row  in  BW_NUM_ROW  number of rows to emit; sampled at start.
- mreg_move_renable  out  1  shift the mreg by one row (row 0 out).
- mreg_move_rdata_list1d  in  BW_TENSOR_ROW  current head row of the mreg.
- store_tensor_row_rvalid  out  1  row beat valid.
- store_tensor_row_rlast  out  1  last emitted row.
- store_tensor_row_rdata  out  BW_TENSOR_ROW  row data.
- store_tensor_row_rready  in  1  downstream accepts the beat.
- store_done  out  1  one-cycle pulse when all MATRIX_NUM_ROW shifts are complete.

Behaviour:
- Internal state:
  - state: IDLE, SEND, DRAIN.
  - row_cnt: 0..MATRIX_NUM_ROW-1.
  - num_q: captured row count.
- Reset (rst=1 at a clk edge): state=IDLE, row_cnt=0, num_q=0.
  - Outputs after reset: busy=0, storereg_wready=1, mreg_move_renable=0, rvalid=0, rlast=0, rdata=0, store_done=0.
- clear has the same effect as rst, has priority over enable, and may occur mid-matrix. The partially shifted mreg is left as is; the owner reloads it.
- IDLE:
  - storereg_wready=1.
  - On enable & storereg_wrequest: num_q = min(store_num_row, MATRIX_NUM_ROW), row_cnt=0.
  - Next state is SEND if num_q>0, otherwise DRAIN (a zero count emits nothing).
- SEND:
  - rvalid = enable.
  - rdata = mreg_move_rdata_list1d, passed through combinationally (zero latency from mreg head to stream).
  - rlast = (row_cnt == num_q-1).
  - Handshake hs = rvalid & rready. mreg_move_renable = hs.
  - On hs with not last: row_cnt+1.
  - On hs with last:
    - if row_cnt == MATRIX_NUM_ROW-1: go to IDLE, pulse store_done, row_cnt=0.
    - otherwise: row_cnt+1, go to DRAIN.
  - rready low stalls the block indefinitely; rdata stays stable because no shift occurs.
- DRAIN:
  - rvalid=0.
  - mreg_move_renable = enable, one row per enabled cycle; row_cnt+1 per shift.
  - On the shift with row_cnt == MATRIX_NUM_ROW-1: go to IDLE, pulse store_done (same cycle as that shift), row_cnt=0.
- Outside SEND: rdata=0 and rlast=0.
- Shift count: exactly MATRIX_NUM_ROW renable pulses per started matrix (unless cleared). A full matrix with no stalls takes MATRIX_NUM_ROW cycles from the first beat.
- storereg_wrequest is ignored outside IDLE.
- A new request is accepted at the earliest one cycle after store_done, from IDLE.
- enable low mid-SEND: rvalid drops. Stream sinks in this subsystem tolerate valid withdrawal under enable gating.

Optional Feature:
- Macro: DCA_MATRIX_MREG2STORE_COL_MASK_EN.
- Defined:
  - Adds input store_num_col [clog2(MATRIX_NUM_COL+1)-1:0], sampled with store_num_row at start and clamped to MATRIX_NUM_COL.
  - Scalars at column index >= num_col_q are driven to zero in rdata.
  - num_col_q = 0 zeros the whole row.
- Not defined: the port is absent and all columns pass through unmodified.

Test Plan:
1. ROW=4, num_row=4, rready=1: 4 beats on consecutive cycles, rlast on beat 3, renable on 4 cycles, store_done coincides with beat 3, DRAIN never entered.
2. num_row=2: 2 beats with rlast on the 2nd, then 2 DRAIN shifts (rvalid=0), store_done on the 4th shift; total renable count = 4.
3. rready toggles 1,0,0,1,...: no renable while rready=0, rdata held stable, beat order row0..row3 preserved.
4. num_row=0, then num_row=7: first case gives 0 beats, 4 drain shifts and store_done; second is clamped to 4 beats.
5. clear asserted after beat 1 of 4: next cycle shows IDLE, storereg_wready=1, rvalid=0, no store_done. A following request restarts with row_cnt=0.
6. COL_MASK_EN with num_col=1, COL=4, rows 0xFFFF...: each beat carries only scalar 0 non-zero; scalars 1–3 are 0.
